// File: rtl/gcd_engine.sv
// Sequential binary (Stein) GCD unit for the ALU/LCD calculator.
// Operands are captured on a synchronised, qualified rising edge of trig.
module gcd_engine #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned ITER_W   = 6,
  parameter int unsigned MAX_ITER = 40
) (
  input  logic              lcdclk,
  input  logic              resetn,
  input  logic              trig,
  input  logic              en,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic [WIDTH-1:0]  result,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam int unsigned KW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_n;
  logic               s1, s2, d;
  logic               trig_edge, accept, last_step, fin;
  logic [WIDTH-1:0]   a, b, a_n, b_n, res_n;
  logic [KW-1:0]      k, k_n;
  logic [ITER_W-1:0]  iter_n;
  logic               done_n, valid_n, err_n;

  assign trig_edge = s2 & ~d;
  // Holding off during the done cycle keeps done from overlapping an accept.
  assign accept    = trig_edge & en & (state != CALC) & ~done;
  assign last_step = (iter_cnt == ITER_W'(MAX_ITER - 1));
  assign busy      = (state == CALC);

  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= trig;
      s2 <= s1;
      d  <= s2;
    end
  end

  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    k_n     = k;
    res_n   = result;
    err_n   = err;
    valid_n = valid;
    iter_n  = iter_cnt;
    done_n  = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          a_n     = a_in;
          b_n     = b_in;
          k_n     = '0;
          iter_n  = '0;
          valid_n = 1'b0;
          err_n   = 1'b0;
          state_n = CALC;
        end
      end
      CALC: begin
        iter_n = iter_cnt + 1'b1;
        fin    = 1'b1;
        if (a == '0 && b == '0) begin
          res_n = '0;
          err_n = 1'b1;
        end else if (a == '0) begin
          res_n = b << k;
        end else if (b == '0) begin
          res_n = a << k;
        end else if (a == b) begin
          res_n = a << k;
        end else begin
          fin = 1'b0;
          if (!a[0] && !b[0]) begin
            a_n = a >> 1;
            b_n = b >> 1;
            k_n = k + 1'b1;
          end else if (!a[0]) begin
            a_n = a >> 1;
          end else if (!b[0]) begin
            b_n = b >> 1;
          end else if (a > b) begin
            a_n = (a - b) >> 1;
          end else begin
            b_n = (b - a) >> 1;
          end
          if (last_step) begin
            fin   = 1'b1;
            res_n = '0;
            err_n = 1'b1;
          end
        end
        if (fin) begin
          state_n = DONE;
          done_n  = 1'b1;
          valid_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      a        <= '0;
      b        <= '0;
      k        <= '0;
      result   <= '0;
      err      <= 1'b0;
      valid    <= 1'b0;
      done     <= 1'b0;
      iter_cnt <= '0;
    end else begin
      a        <= a_n;
      b        <= b_n;
      k        <= k_n;
      result   <= res_n;
      err      <= err_n;
      valid    <= valid_n;
      done     <= done_n;
      iter_cnt <= iter_n;
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: a 12-bit and an 8-bit instance share stimulus and are
// checked every cycle against a Euclid-based model of the trigger/result protocol.
module tb_gcd_engine;

  logic        lcdclk = 1'b0;
  logic        resetn;
  logic        trig;
  logic        en;
  logic [11:0] a_in, b_in;

  logic [11:0] r12;
  logic [7:0]  r8;
  logic        busy12, done12, valid12, err12;
  logic        busy8, done8, valid8, err8;
  logic [5:0]  it12;
  logic [4:0]  it8;

  always #5 lcdclk = ~lcdclk;

  gcd_engine #(.WIDTH(12), .ITER_W(6), .MAX_ITER(40)) u12 (
    .lcdclk(lcdclk), .resetn(resetn), .trig(trig), .en(en),
    .a_in(a_in), .b_in(b_in), .result(r12), .busy(busy12), .done(done12),
    .valid(valid12), .err(err12), .iter_cnt(it12)
  );

  gcd_engine #(.WIDTH(8), .ITER_W(5), .MAX_ITER(25)) u8 (
    .lcdclk(lcdclk), .resetn(resetn), .trig(trig), .en(en),
    .a_in(a_in[7:0]), .b_in(b_in[7:0]), .result(r8), .busy(busy8), .done(done8),
    .valid(valid8), .err(err8), .iter_cnt(it8)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input int unsigned idx,
                       input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Model state, one slot per instance (0: 12-bit, 1: 8-bit)
  bit          m_s1, m_s2, m_d;
  bit          pending   [2];
  bit          done_seen [2];
  bit          exp_gerr  [2];
  bit          exp_err   [2];
  bit          exp_valid [2];
  int unsigned exp_gcd   [2];
  int unsigned exp_res   [2];
  int unsigned wait_cnt  [2];
  int unsigned done_cnt  [2] = '{0, 0};
  int unsigned max_iter  [2] = '{40, 25};

  always @(posedge lcdclk or negedge resetn) begin
    if (!resetn) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_d = 1'b0;
      for (int i = 0; i < 2; i++) begin
        pending[i] = 1'b0; done_seen[i] = 1'b0; exp_err[i] = 1'b0;
        exp_valid[i] = 1'b0; exp_res[i] = 0; wait_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int unsigned oa, ob;
        oa = (i == 0) ? int'(a_in) : int'(a_in[7:0]);
        ob = (i == 0) ? int'(b_in) : int'(b_in[7:0]);
        if (m_s2 && !m_d && en && !pending[i] && !done_seen[i]) begin
          pending[i]   = 1'b1;
          exp_valid[i] = 1'b0;
          exp_err[i]   = 1'b0;
          exp_gcd[i]   = ref_gcd(oa, ob);
          exp_gerr[i]  = (oa == 0 && ob == 0);
          wait_cnt[i]  = 0;
        end else if (pending[i]) begin
          wait_cnt[i]++;
        end
        done_seen[i] = 1'b0;
      end
      m_d = m_s2; m_s2 = m_s1; m_s1 = trig;
    end
  end

  always @(negedge lcdclk) begin
    for (int i = 0; i < 2; i++) begin
      int unsigned res, it;
      bit bz, dn, vl, er;
      res = (i == 0) ? int'(r12) : int'(r8);
      it  = (i == 0) ? int'(it12) : int'(it8);
      bz  = (i == 0) ? busy12 : busy8;
      dn  = (i == 0) ? done12 : done8;
      vl  = (i == 0) ? valid12 : valid8;
      er  = (i == 0) ? err12 : err8;
      if (!resetn) begin
        check("rst_result", i, res, 0);
        check("rst_busy", i, bz, 0);
        check("rst_done", i, dn, 0);
        check("rst_valid", i, vl, 0);
        check("rst_err", i, er, 0);
        check("rst_iter", i, it, 0);
      end else if (pending[i] && dn) begin
        done_cnt[i]++;
        check("result", i, res, exp_gcd[i]);
        check("err", i, er, exp_gerr[i]);
        check("valid_at_done", i, vl, 1);
        check("busy_at_done", i, bz, 0);
        check("iter_range", i, (it >= 1 && it <= max_iter[i]) ? 1 : 0, 1);
        pending[i]   = 1'b0;
        done_seen[i] = 1'b1;
        exp_res[i]   = exp_gcd[i];
        exp_err[i]   = exp_gerr[i];
        exp_valid[i] = 1'b1;
      end else if (pending[i]) begin
        check("busy_in_calc", i, bz, 1);
        check("valid_in_calc", i, vl, 0);
        check("err_in_calc", i, er, 0);
        if (wait_cnt[i] > max_iter[i] + 1) begin
          check("done_timeout", i, wait_cnt[i], max_iter[i] + 1);
          pending[i] = 1'b0;
        end
      end else begin
        if (dn) done_cnt[i]++;
        check("done_idle", i, dn, 0);
        check("busy_idle", i, bz, 0);
        check("valid_held", i, vl, exp_valid[i]);
        check("err_held", i, er, exp_err[i]);
        check("result_held", i, res, exp_res[i]);
      end
    end
  end

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while ((busy12 || busy8) && n < 100) begin
      @(posedge lcdclk); #1;
      n++;
    end
    if (n >= 100) check("idle_timeout", 0, n, 0);
  endtask

  task automatic run_op(input logic [11:0] a, input logic [11:0] b, input logic e);
    a_in = a; b_in = b; en = e; trig = 1'b1;
    repeat (4) @(posedge lcdclk);
    #1;
    wait_idle();
    trig = 1'b0;
    repeat (4) @(posedge lcdclk);
    #1;
  endtask

  task automatic pin(input string name, input int unsigned r, input int unsigned it,
                     input bit e);
    check({name, "_result"}, 0, r12, r);
    check({name, "_iter"}, 0, it12, it);
    check({name, "_err"}, 0, err12, e);
    check({name, "_valid"}, 0, valid12, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned dc0;
    resetn = 1'b0; trig = 1'b0; en = 1'b1; a_in = '0; b_in = '0;
    repeat (3) @(posedge lcdclk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge lcdclk);
    #1;

    run_op(12'd48, 12'd18, 1'b1);     pin("g48_18", 6, 6, 1'b0);
    run_op(12'd0, 12'd25, 1'b1);      pin("g0_25", 25, 1, 1'b0);
    run_op(12'd0, 12'd0, 1'b1);       pin("g0_0", 0, 1, 1'b1);
    run_op(12'd4095, 12'd4095, 1'b1); pin("g4095", 4095, 1, 1'b0);
    run_op(12'd2048, 12'd1024, 1'b1); pin("g2048_1024", 1024, 12, 1'b0);

    dc0 = done_cnt[0];
    run_op(12'd7, 12'd5, 1'b0);
    check("en_low_result", 0, r12, 1024);
    check("en_low_no_done", 0, done_cnt[0] - dc0, 0);

    // Second edge arrives while the (48,18) op is still stepping
    dc0 = done_cnt[0];
    a_in = 12'd48; b_in = 12'd18; en = 1'b1; trig = 1'b1;
    repeat (4) @(posedge lcdclk);
    #1 trig = 1'b0;
    @(posedge lcdclk);
    #1 trig = 1'b1;
    wait_idle();
    repeat (6) @(posedge lcdclk);
    #1;
    check("busy_edge_result", 0, r12, 6);
    check("busy_edge_one_done", 0, done_cnt[0] - dc0, 1);
    trig = 1'b0;
    repeat (4) @(posedge lcdclk);
    #1;

    dc0 = done_cnt[0];
    a_in = 12'd48; b_in = 12'd18; trig = 1'b1;
    repeat (5) @(posedge lcdclk);
    #1 resetn = 1'b0; trig = 1'b0;
    repeat (2) @(posedge lcdclk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge lcdclk);
    #1;
    check("reset_no_done", 0, done_cnt[0] - dc0, 0);
    check("reset_valid", 0, valid12, 0);
    run_op(12'd48, 12'd18, 1'b1);     pin("after_reset", 6, 6, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      logic [11:0] ra, rb;
      ra = 12'($urandom_range(0, 4095));
      rb = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 15) == 0) ra = '0;
      if ($urandom_range(0, 15) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) rb = ra;
      run_op(ra, rb, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
